// File: rtl/ata_pkg.sv
// Shared types and constants for the Gayle-window IDE PIO sequencer:
// FSM states, the PIO timing table and the address window.
package ata_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACTIVE  = 3'd2,
    WAITRDY = 3'd3,
    DONE    = 3'd4,
    FAULT   = 3'd5,
    RECOVER = 3'd6
  } ata_state_e;

  // Per-mode phase lengths in CLK cycles.
  typedef struct packed {
    logic [7:0] t1;
    logic [7:0] t2;
    logic [7:0] tr;
  } pio_timing_t;

  // A[23:15] of the 0xDA0000-0xDA7FFF IDE window.
  localparam logic [8:0] GAYLE_WIN = 9'b1101_1010_0;

  // MODE 3 selects PIO4; PIO3 is not offered.
  function automatic pio_timing_t pio_timing(input logic [1:0] mode);
    pio_timing_t tm;
    case (mode)
      2'd0:    tm = '{t1: 8'd4, t2: 8'd9, tr: 8'd19};
      2'd1:    tm = '{t1: 8'd3, t2: 8'd7, tr: 8'd11};
      2'd2:    tm = '{t1: 8'd2, t2: 8'd5, tr: 8'd6};
      default: tm = '{t1: 8'd2, t2: 8'd4, tr: 8'd2};
    endcase
    return tm;
  endfunction

endpackage

// File: rtl/ata_pio_sequencer_if.sv
// CPU-side and IDE-side signals of the PIO sequencer, grouped as one bundle.
// Handshake: AS low opens a cycle; the sequencer answers with exactly one of
// DTACK or BERR low (or neither on an early AS release) and holds it until AS is
// seen high again. All active-low except RW (1 = read) and IORDY (1 = ready).
interface ata_pio_sequencer_if;
  logic        AS;
  logic        RW;
  logic [23:0] A;
  logic [1:0]  MODE;
  logic        IORDY;
  logic [1:0]  IDECS;
  logic        IOR;
  logic        IOW;
  logic        DTACK;
  logic        BERR;
  logic        ACCESS;

  modport master (
    output AS, RW, A, MODE, IORDY,
    input  IDECS, IOR, IOW, DTACK, BERR, ACCESS
  );

  modport slave (
    input  AS, RW, A, MODE, IORDY,
    output IDECS, IOR, IOW, DTACK, BERR, ACCESS
  );
endinterface

// File: rtl/ata_pio_timer.sv
// Loadable down-counter that stops at zero; load wins over enable.
module ata_pio_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ata_pio_sequencer.sv
// IDE PIO strobe sequencer for the Gayle window: chip-select setup, strobe
// active time stretched by IORDY, BERR on a hung drive, and recovery time.
module ata_pio_sequencer
  import ata_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  ata_pio_sequencer_if.slave  bus,
  output ata_state_e          state_o
);

  ata_state_e  state_q, state_d;
  logic        asq_q;
  logic        rdy_meta_q, rdyq_q;
  logic [1:0]  mode_q, mode_d;
  logic        rw_q, rw_d;
  logic [1:0]  idecs_q, idecs_d;
  logic        ior_q, ior_d;
  logic        iow_q, iow_d;
  logic        dtack_q, dtack_d;
  logic        berr_q, berr_d;

  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             tmo_load, tmo_en, tmo_zero;

  logic        sel;
  logic        abort;
  pio_timing_t tm_new, tm_cur;

  logic unused_a;
  assign unused_a = ^{bus.A[14:13], bus.A[11:0]};

  function automatic logic [CNT_W-1:0] minus1(input logic [7:0] t);
    return CNT_W'(t - 8'd1);
  endfunction

  assign bus.ACCESS = (bus.A[23:15] == GAYLE_WIN) ? 1'b0 : 1'b1;
  assign sel        = ~asq_q & ~bus.ACCESS;
  assign tm_new     = pio_timing(bus.MODE);
  assign tm_cur     = pio_timing(mode_q);
  assign abort      = asq_q && ((state_q == SETUP) || (state_q == ACTIVE) ||
                                (state_q == WAITRDY));

  ata_pio_timer #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  ata_pio_timer #(.CNT_W(CNT_W)) u_tmo (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .load_i     (tmo_load),
    .load_val_i (CNT_W'(TIMEOUT)),
    .en_i       (tmo_en),
    .zero_o     (tmo_zero)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rw_d     = rw_q;
    idecs_d  = idecs_q;
    ior_d    = ior_q;
    iow_d    = iow_q;
    dtack_d  = dtack_q;
    berr_d   = berr_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;
    tmo_load = 1'b0;
    tmo_en   = 1'b0;

    if (abort) begin
      // CPU gave up before completion: drop everything, still honour recovery.
      ior_d    = 1'b1;
      iow_d    = 1'b1;
      idecs_d  = 2'b11;
      cnt_load = 1'b1;
      cnt_val  = minus1(tm_cur.tr);
      state_d  = RECOVER;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel) begin
            idecs_d  = bus.A[12] ? 2'b01 : 2'b10;
            mode_d   = bus.MODE;
            rw_d     = bus.RW;
            cnt_load = 1'b1;
            cnt_val  = minus1(tm_new.t1);
            state_d  = SETUP;
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            if (rw_q) ior_d = 1'b0;
            else      iow_d = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = minus1(tm_cur.t2);
            state_d  = ACTIVE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ACTIVE: begin
          if (cnt_zero) begin
            if (rdyq_q) begin
              ior_d   = 1'b1;
              iow_d   = 1'b1;
              dtack_d = 1'b0;
              state_d = DONE;
            end else begin
              tmo_load = 1'b1;
              state_d  = WAITRDY;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        WAITRDY: begin
          if (rdyq_q) begin
            ior_d   = 1'b1;
            iow_d   = 1'b1;
            dtack_d = 1'b0;
            state_d = DONE;
          end else if (tmo_zero) begin
            ior_d   = 1'b1;
            iow_d   = 1'b1;
            berr_d  = 1'b0;
            state_d = FAULT;
          end else begin
            tmo_en = 1'b1;
          end
        end
        DONE: begin
          if (asq_q) begin
            dtack_d  = 1'b1;
            idecs_d  = 2'b11;
            cnt_load = 1'b1;
            cnt_val  = minus1(tm_cur.tr);
            state_d  = RECOVER;
          end
        end
        FAULT: begin
          if (asq_q) begin
            berr_d   = 1'b1;
            idecs_d  = 2'b11;
            cnt_load = 1'b1;
            cnt_val  = minus1(tm_cur.tr);
            state_d  = RECOVER;
          end
        end
        RECOVER: begin
          if (cnt_zero) state_d = IDLE;
          else          cnt_en  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      asq_q      <= 1'b1;
      rdy_meta_q <= 1'b0;
      rdyq_q     <= 1'b0;
      mode_q     <= 2'd0;
      rw_q       <= 1'b1;
      idecs_q    <= 2'b11;
      ior_q      <= 1'b1;
      iow_q      <= 1'b1;
      dtack_q    <= 1'b1;
      berr_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      asq_q      <= bus.AS;
      rdy_meta_q <= bus.IORDY;
      rdyq_q     <= rdy_meta_q;
      mode_q     <= mode_d;
      rw_q       <= rw_d;
      idecs_q    <= idecs_d;
      ior_q      <= ior_d;
      iow_q      <= iow_d;
      dtack_q    <= dtack_d;
      berr_q     <= berr_d;
    end
  end

  assign bus.IDECS = idecs_q;
  assign bus.IOR   = ior_q;
  assign bus.IOW   = iow_q;
  assign bus.DTACK = dtack_q;
  assign bus.BERR  = berr_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ata_pio_sequencer.sv
// Bench for ata_pio_sequencer: directed CPU cycles, an interval-based expected
// waveform model compared every cycle, plus literal timing expectations.
module tb_ata_pio_sequencer;
  import ata_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  ata_state_e state;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         chk_en = 1'b0;

  ata_pio_sequencer_if bus();

  ata_pio_sequencer #(.TIMEOUT(255), .CNT_W(8)) dut (
    .CLK     (clk),
    .RESET   (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock / cycle index ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model ----------------
  int t1_tab[4] = '{4, 3, 2, 2};
  int t2_tab[4] = '{9, 7, 5, 4};
  int tr_tab[4] = '{19, 11, 6, 2};

  // Low intervals [from, to) in posedge indices for one CPU cycle.
  typedef struct {
    int         id_from, id_to;
    logic [1:0] id_val;
    int         st_from, st_to;
    bit         st_rd;
    int         dt_from, dt_to;
    int         be_from, be_to;
  } txn_t;

  txn_t txq[$];
  int   idle_from = 0;

  function automatic bit in_window(input logic [23:0] a);
    return (a >= 24'hDA0000) && (a <= 24'hDA7FFF);
  endfunction

  function automatic logic [6:0] exp_vec(input int c);
    logic [6:0] e;
    e = {2'b11, 4'b1111, ~in_window(bus.A)};
    foreach (txq[i]) begin
      if (c >= txq[i].id_from && c < txq[i].id_to) e[6:5] = txq[i].id_val;
      if (c >= txq[i].st_from && c < txq[i].st_to) begin
        if (txq[i].st_rd) e[4] = 1'b0;
        else              e[3] = 1'b0;
      end
      if (c >= txq[i].dt_from && c < txq[i].dt_to) e[2] = 1'b0;
      if (c >= txq[i].be_from && c < txq[i].be_to) e[1] = 1'b0;
    end
    return e;
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [6:0] act, exp_v;
    if (chk_en) begin
      act   = {bus.IDECS, bus.IOR, bus.IOW, bus.DTACK, bus.BERR, bus.ACCESS};
      exp_v = exp_vec(cyc);
      checks++;
      if (act !== exp_v) begin
        errors++;
        if (errors < 20)
          $display("FAIL cycle_cmp cyc=%0d got=%b exp=%b (IDECS,IOR,IOW,DTACK,BERR,ACCESS)",
                   cyc, act, exp_v);
      end
    end
  end

  // ---------------- event monitor ----------------
  logic [1:0] p_idecs = 2'b11;
  logic p_ior = 1'b1, p_iow = 1'b1, p_dtack = 1'b1, p_berr = 1'b1;
  int n_ior_fall = 0, n_iow_fall = 0, n_dtack_fall = 0, n_berr_fall = 0, n_idecs_fall = 0;
  int ior_fall_at = 0, ior_rise_at = 0, iow_fall_at = 0, iow_rise_at = 0;
  int dtack_fall_at = 0, berr_fall_at = 0, idecs_fall_at = 0, idecs_rise_at = 0;
  int idecs_gap = 0, rec_cnt = 0;
  logic [1:0] idecs_fall_val = 2'b11;

  always @(negedge clk) begin
    if (p_ior && !bus.IOR) begin n_ior_fall++; ior_fall_at = cyc; end
    if (!p_ior && bus.IOR) ior_rise_at = cyc;
    if (p_iow && !bus.IOW) begin n_iow_fall++; iow_fall_at = cyc; end
    if (!p_iow && bus.IOW) iow_rise_at = cyc;
    if (p_dtack && !bus.DTACK) begin n_dtack_fall++; dtack_fall_at = cyc; end
    if (p_berr && !bus.BERR) begin n_berr_fall++; berr_fall_at = cyc; end
    if (p_idecs == 2'b11 && bus.IDECS != 2'b11) begin
      n_idecs_fall++;
      idecs_gap      = cyc - idecs_rise_at;
      idecs_fall_at  = cyc;
      idecs_fall_val = bus.IDECS;
    end
    if (p_idecs != 2'b11 && bus.IDECS == 2'b11) idecs_rise_at = cyc;
    if (state == RECOVER) rec_cnt++;
    p_idecs = bus.IDECS; p_ior = bus.IOR; p_iow = bus.IOW;
    p_dtack = bus.DTACK; p_berr = bus.BERR;
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // rdy_rel < 0: IORDY high throughout; else IORDY low, rising before edge t0+rdy_rel.
  // as_hi_rel > 0: AS seen high at edge t0+as_hi_rel; 0: two cycles after completion.
  task automatic run_txn(input logic [1:0] mode, input logic rw, input logic [23:0] addr,
                         input int rdy_rel, input int as_hi_rel);
    int c, t0, s, d, r, done_e, end_e, hi, rel;
    bit fault;
    txn_t t;
    c = cyc;
    bus.A = addr; bus.RW = rw; bus.MODE = mode; bus.AS = 1'b0;
    bus.IORDY = (rdy_rel < 0);
    if (!in_window(addr)) begin
      repeat (6) @(posedge clk);
      #1 bus.AS = 1'b1; bus.IORDY = 1'b1;
      idle(1);
      return;
    end
    t0     = (c + 1 > idle_from) ? c + 1 : idle_from;
    s      = t0 + 1 + t1_tab[mode];
    d      = s + t2_tab[mode];
    r      = t0 + rdy_rel;
    done_e = (rdy_rel < 0 || r + 2 <= d) ? d : r + 2;
    fault  = done_e > d + 256;
    end_e  = fault ? d + 256 : done_e;
    hi     = (as_hi_rel > 0) ? as_hi_rel : end_e - t0 + 2;
    rel    = t0 + hi + 1;
    t.id_from = t0 + 1;  t.id_to = rel;
    t.id_val  = addr[12] ? 2'b01 : 2'b10;
    t.st_from = s;       t.st_to = (rel < end_e) ? rel : end_e;
    t.st_rd   = rw;
    t.dt_from = 0; t.dt_to = 0; t.be_from = 0; t.be_to = 0;
    if (rel > end_e) begin
      if (fault) begin t.be_from = end_e; t.be_to = rel; end
      else       begin t.dt_from = end_e; t.dt_to = rel; end
    end
    txq.push_back(t);
    idle_from = rel + tr_tab[mode];
    while (cyc < t0 + hi) begin
      @(posedge clk);
      #1;
      if (rdy_rel >= 0 && cyc == r - 1) bus.IORDY = 1'b1;
      if (cyc == t0 + 2) begin
        bus.MODE = ~mode; bus.RW = ~rw; bus.A[12] = ~addr[12];
      end
      if (cyc == t0 + hi - 1) bus.AS = 1'b1;
    end
    bus.IORDY = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n0, n1, n2;
    bus.AS = 1'b1; bus.RW = 1'b1; bus.A = 24'h000000; bus.MODE = 2'd0; bus.IORDY = 1'b1;
    rst_n = 1'b0;
    idle(3);
    chk("reset_outputs", int'({bus.IDECS, bus.IOR, bus.IOW, bus.DTACK, bus.BERR}), 63);
    chk("reset_state", int'(state), int'(IDLE));
    rst_n = 1'b1;
    idle(2);
    chk_en = 1'b1;

    // PIO0 read
    rec_cnt = 0;
    run_txn(2'd0, 1'b1, 24'hDA2000, -1, 0);
    chk("access_in_window", int'(bus.ACCESS), 0);
    idle(25);
    chk("pio0_idecs_val", int'(idecs_fall_val), 2);
    chk("pio0_setup_len", ior_fall_at - idecs_fall_at, 4);
    chk("pio0_ior_width", ior_rise_at - ior_fall_at, 9);
    chk("pio0_dtack_at", dtack_fall_at - ior_fall_at, 9);
    chk("pio0_recovery", rec_cnt, 19);

    // PIO4 writes, second one back-to-back
    n0 = n_ior_fall; n1 = n_iow_fall;
    run_txn(2'd3, 1'b0, 24'hDA3000, -1, 0);
    n2 = iow_rise_at - iow_fall_at;
    chk("pio4_idecs_val", int'(idecs_fall_val), 1);
    run_txn(2'd3, 1'b0, 24'hDA3000, -1, 0);
    idle(10);
    chk("pio4_iow_width", n2, 4);
    chk("pio4_b2b_gap", idecs_gap, 3);
    chk("pio4_no_ior", n_ior_fall - n0, 0);
    chk("pio4_iow_count", n_iow_fall - n1, 2);

    // PIO2 read, IORDY low 20 cycles past the active phase
    n0 = n_dtack_fall;
    run_txn(2'd2, 1'b1, 24'hDA0000, 28, 0);
    idle(10);
    chk("pio2_ior_width", ior_rise_at - ior_fall_at, 27);
    chk("pio2_dtack_at", dtack_fall_at - ior_fall_at, 27);
    chk("pio2_dtack_count", n_dtack_fall - n0, 1);

    // IORDY stuck low at PIO4
    n0 = n_dtack_fall; n1 = n_berr_fall;
    run_txn(2'd3, 1'b1, 24'hDA1000, 5000, 0);
    rec_cnt = 0;
    idle(10);
    chk("stuck_ior_width", ior_rise_at - ior_fall_at, 260);
    chk("stuck_berr_at", berr_fall_at - ior_fall_at, 260);
    chk("stuck_no_dtack", n_dtack_fall - n0, 0);
    chk("stuck_berr_count", n_berr_fall - n1, 1);
    chk("stuck_recovery", rec_cnt, 2);

    // Out-of-window accesses
    n0 = n_idecs_fall; n1 = n_dtack_fall;
    run_txn(2'd0, 1'b1, 24'hDA8000, -1, 0);
    chk("access_da8000", int'(bus.ACCESS), 1);
    run_txn(2'd0, 1'b0, 24'hF00000, -1, 0);
    chk("access_f00000", int'(bus.ACCESS), 1);
    idle(3);
    chk("oow_no_idecs", n_idecs_fall - n0, 0);
    chk("oow_no_dtack", n_dtack_fall - n1, 0);

    // AS released during SETUP at PIO1
    n0 = n_ior_fall; n1 = n_dtack_fall; n2 = n_berr_fall;
    rec_cnt = 0;
    run_txn(2'd1, 1'b1, 24'hDA1000, -1, 2);
    idle(20);
    chk("abort_no_ior", n_ior_fall - n0, 0);
    chk("abort_no_ack", (n_dtack_fall - n1) + (n_berr_fall - n2), 0);
    chk("abort_recovery", rec_cnt, 11);

    // Asynchronous reset during ACTIVE
    chk_en = 1'b0;
    bus.A = 24'hDA2000; bus.RW = 1'b1; bus.MODE = 2'd0; bus.AS = 1'b0;
    idle(7);
    chk("pre_reset_state", int'(state), int'(ACTIVE));
    chk("pre_reset_ior", int'(bus.IOR), 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({bus.IDECS, bus.IOR, bus.IOW, bus.DTACK, bus.BERR}), 63);
    chk("async_reset_state", int'(state), int'(IDLE));
    bus.AS = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("post_reset_state", int'(state), int'(IDLE));
    txq.delete();
    idle_from = cyc;
    chk_en = 1'b1;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
